window_kxk: RTL
===============

Name: window_kxk

Overview:
- Parametrised successor to the 5-tap column window generator.
- Accepts a raster-scan pixel stream of an IMG_W x IMG_H frame and emits every full K x K neighbourhood, i.e. valid-mode with no padding.
- Each window carries its top-left coordinate and a frame-done flag.
- Sits between the image reader/pixel source and the convolution/PE array; replaces the fixed 28x28, 5-row, 8-bit window.

Parameters:
- DW, 8, pixel width in bits.
- IMG_W, 28, frame width in pixels (must be >= K).
- IMG_H, 28, frame height in pixels (must be >= K).
- K, 5, window edge length (2..7).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a new frame when idle.
- din_valid  in  1  pixel qualifier; one beat per pixel, gaps allowed.
- din  in  DW  pixel, raster order (row-major, column 0 first).
- win_valid  out  1  win/win_x/win_y hold a complete window this cycle.
- win  out  K*K*DW  window; element (r,c) at [((r*K)+c)*DW +: DW].
- win_x  out  clog2(IMG_W)  column of window top-left pixel.
- win_y  out  clog2(IMG_H)  row of window top-left pixel.
- frame_done  out  1  one-cycle pulse, coincident with last window.
- busy  out  1  high from accepted start until frame_done inclusive.

Behaviour:
- Reset, synchronous, active-high: outputs win_valid=0, win=0, win_x=0, win_y=0, frame_done=0, busy=0.
- Reset clears the FSM to IDLE and zeroes the column and row counters.
- Line-buffer contents are not cleared; they are don't-care because win_valid is gated by the counters.
- FSM states: IDLE, FILL, RUN, DONE.
  - IDLE: din_valid ignored. start -> FILL; busy rises the next cycle.
  - FILL: active while the pixel row index < K-1. Pixels are shifted in; no windows are produced. Moves to RUN on the first beat of row K-1.
  - RUN: on each accepted beat at (row y, col x) with x >= K-1, the window with top-left (x-K+1, y-K+1) becomes valid.
  - DONE: entered on the beat at (IMG_H-1, IMG_W-1). Lasts one cycle, then returns to IDLE.
- Latency: win_valid is registered. It asserts exactly one clk after the din_valid beat that completes the window.
- Window contents: element (r,c) = pixel(win_y+r, win_x+c). r=0 is the top (oldest) row; c=0 is the leftmost column.
- Storage:
  - K-1 line buffers, each IMG_W deep, chained, giving the K vertically aligned taps per column.
  - A K x K register array shifts one column left per accepted beat.
- Counters:
  - Column counter wraps IMG_W-1 -> 0 and increments the row counter.
  - Row counter stops at IMG_H-1.
- Window count per frame is (IMG_W-K+1)*(IMG_H-K+1).
- Stalls: din_valid=0 freezes all shift state, counters and the FSM. win_valid is 0 in stall cycles.
- frame_done asserts in the same cycle as the final win_valid, whose top-left is (IMG_W-K, IMG_H-K). busy also drops after that cycle.
- start while busy is ignored, with no restart and no counter change.
- start in the same cycle as the DONE state is also ignored.
- Beats after the last pixel, before a new start, are ignored.
- rst asserted mid-frame takes priority over start and din_valid in that cycle. The next frame requires a fresh start.

Decomposition:
- Package window_pkg holds:
  - a clog2 function;
  - the FSM state encoding localparams (IDLE, FILL, RUN, DONE);
  - a helper computing the window count from IMG_W, IMG_H and K.
- Sub-module line_buffer, parameters DW and DEPTH:
  - one circular-RAM or shift delay line with an enable input;
  - instantiated K-1 times from a generate loop.

Test Plan:
- Reset and idle: assert rst for 3 cycles, then din_valid=1 without start -> all outputs 0, no win_valid.
- Ramp frame, default parameters (pixel = (y*28+x) mod 256):
  - first win_valid one clk after beat 116 (row 4, col 4), with win(0,0)=0 and win(4,4)=116;
  - exactly 576 windows in total;
  - last window has win_x=23, win_y=23, win(0,0)=155, win(4,4)=15, with frame_done=1 in the same cycle.
- Random din_valid gaps (~40% idle cycles) on the same ramp -> window sequence identical to the gap-free run; win_valid never asserted in stall cycles.
- Re-start and reset mid-frame:
  - start pulsed again at pixel 200 -> ignored, frame completes normally;
  - rst at pixel 300 -> outputs zero next cycle, busy=0; a new start plus a full frame gives the correct 576 windows.
- Parameter sweep K=3, IMG_W=8, IMG_H=6, ramp pixel = y*8+x -> 24 windows; first window has win(2,2)=18; last window has win_x=5, win_y=3 with frame_done.
- Back-to-back frames, with start issued the cycle after frame_done -> second frame is correct and busy is continuous apart from one idle cycle.

Source files
------------

// File: rtl/window_pkg.sv
// Shared helpers for the K x K window generator: width function, FSM encoding, window count.
package window_pkg;

  function automatic int clog2(input int v);
    int r;
    int t;
    r = 0;
    t = v - 1;
    while (t > 0) begin
      r = r + 1;
      t = t >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    FILL = ST_FILL,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  function automatic int win_count(input int w, input int h, input int k);
    return (w - k + 1) * (h - k + 1);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Circular-RAM delay line: dout is the sample written DEPTH enabled beats ago.
// Zero latency read; en=0 freezes pointer and contents, no backpressure.
module line_buffer
  import window_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 28
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam int AW = clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ptr;

  // Read-before-write at the same slot yields exactly DEPTH beats of delay.
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/window_kxk.sv
// Raster pixel stream in, every full K x K neighbourhood out (valid mode) with top-left coords.
// win_valid registered one clk after the completing beat; din_valid gaps stall everything.
module window_kxk
  import window_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    din_valid,
  input  logic [DW-1:0]           din,
  output logic                    win_valid,
  output logic [K*K*DW-1:0]       win,
  output logic [clog2(IMG_W)-1:0] win_x,
  output logic [clog2(IMG_H)-1:0] win_y,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int XW = clog2(IMG_W);
  localparam int YW = clog2(IMG_H);

  state_t          state;
  logic [XW-1:0]   col;
  logic [YW-1:0]   row;
  logic            beat;
  logic            last_col;
  logic            last_pix;
  logic [DW-1:0]   tap     [K];
  logic [DW-1:0]   win_arr [K][K];

  assign beat     = din_valid && (state == FILL || state == RUN);
  assign last_col = (col == XW'(IMG_W - 1));
  assign last_pix = last_col && (row == YW'(IMG_H - 1));

  // tap[j] is the pixel j rows above the incoming one, same column.
  assign tap[0] = din;

  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    line_buffer #(
      .DW    (DW),
      .DEPTH (IMG_W)
    ) u_lb (
      .clk  (clk),
      .rst  (rst),
      .en   (beat),
      .din  (tap[j]),
      .dout (tap[j+1])
    );
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign win[((r*K)+c)*DW +: DW] = win_arr[r][c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_arr[r][c] <= '0;
        end
      end
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (beat) begin
        // Row 0 of the array is the oldest line, so it takes the deepest tap.
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) begin
            win_arr[r][c] <= win_arr[r][c+1];
          end
          win_arr[r][K-1] <= tap[K-1-r];
        end
        if (last_col) begin
          col <= '0;
          if (row != YW'(IMG_H - 1)) row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= FILL;
            busy  <= 1'b1;
            col   <= '0;
            row   <= '0;
          end
        end
        FILL: begin
          if (din_valid && row == YW'(K - 1)) state <= RUN;
        end
        RUN: begin
          if (din_valid) begin
            if (col >= XW'(K - 1)) begin
              win_valid <= 1'b1;
              win_x     <= col - XW'(K - 1);
              win_y     <= row - YW'(K - 1);
            end
            if (last_pix) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
